// File: rtl/sm83_bus_pkg.sv
// sm83_bus_pkg: shared types and constants for the SM83 memory bus controller.
package sm83_bus_pkg;

  // Bus sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } bus_state_t;

  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'hFF;
  localparam logic [15:0] BOOT_LOCK_ADDR   = 16'hFF50;
  localparam int          ROM_AW           = 8;
  localparam int          WRAM_AW          = 13;

endpackage

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences one CPU request at a time onto the bootrom or WRAM.
// The address decoder sits outside this block: it sees dec_addr and returns
// rom_sel / wram_sel / phys_addr combinationally.
// Optional feature macro: BOOTROM_LOCK_EN (sticky bootrom unmap via 16'hFF50).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for cpu_req; request is latched on the accepting edge
// ST_DECODE | decoder results valid; pick mapped target or unmapped path
// ST_ACCESS | one-cycle enable pulse to the selected memory
// ST_WAIT   | wait counter runs down; read data captured when it is zero
// ST_RESP   | cpu_ack high for one cycle
module mem_bus_ctrl
  import sm83_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  OPEN_BUS    = OPEN_BUS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [15:0]          cpu_addr,
  input  logic [7:0]           cpu_wdata,
  output logic                 cpu_ack,
  output logic [7:0]           cpu_rdata,
  output logic [15:0]          dec_addr,
  input  logic                 rom_sel,
  input  logic                 wram_sel,
  input  logic [15:0]          phys_addr,
  output logic                 rom_en,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [7:0]           rom_rdata,
  output logic                 wram_en,
  output logic                 wram_we,
  output logic [WRAM_AW-1:0]   wram_addr,
  output logic [7:0]           wram_wdata,
  input  logic [7:0]           wram_rdata,
  output logic                 boot_lock
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  bus_state_t  state, state_nxt;
  logic [15:0] addr_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic        tgt_rom_q;
  logic [3:0]  wait_cnt;
  logic        boot_lock_q;
  logic        lock_wr;
  logic        rom_hit;
  logic        map_ok;
  logic        unused_phys;

`ifdef BOOTROM_LOCK_EN
  assign lock_wr = we_q && (addr_q == BOOT_LOCK_ADDR) && (wdata_q != 8'h00);

  // Sticky bootrom lock, set by the lock write and cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      boot_lock_q <= 1'b0;
    else if (state == ST_DECODE && lock_wr)
      boot_lock_q <= 1'b1;
  end
`else
  assign lock_wr     = 1'b0;
  assign boot_lock_q = 1'b0;
`endif

  // A locked bootrom looks unmapped; ROM writes and the lock write take the
  // unmapped path so they are acked without touching memory.
  assign rom_hit = rom_sel & ~boot_lock_q;
  assign map_ok  = (rom_hit ^ wram_sel) && !(rom_hit && we_q) && !lock_wr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (cpu_req) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = map_ok ? ST_ACCESS : ST_RESP;
      ST_ACCESS: state_nxt = ST_WAIT;
      ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latches, target select, wait counter and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= 16'h0000;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      tgt_rom_q <= 1'b0;
      wait_cnt  <= 4'd0;
      cpu_rdata <= OPEN_BUS;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
          end
        end
        ST_DECODE: begin
          tgt_rom_q <= rom_hit;
          if (!map_ok) cpu_rdata <= OPEN_BUS;
        end
        ST_ACCESS: wait_cnt <= WAIT_INIT;
        ST_WAIT: begin
          if (wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
          else if (!we_q)
            cpu_rdata <= tgt_rom_q ? rom_rdata : wram_rdata;
        end
        default: ;
      endcase
    end
  end

  assign dec_addr    = addr_q;
  assign cpu_ack     = (state == ST_RESP);
  assign rom_en      = (state == ST_ACCESS) && tgt_rom_q;
  assign wram_en     = (state == ST_ACCESS) && !tgt_rom_q;
  assign wram_we     = wram_en && we_q;
  assign rom_addr    = phys_addr[ROM_AW-1:0];
  assign wram_addr   = phys_addr[WRAM_AW-1:0];
  assign wram_wdata  = wdata_q;
  assign boot_lock   = boot_lock_q;
  assign unused_phys = ^phys_addr[15:WRAM_AW];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed vector bench for mem_bus_ctrl (WAIT_STATES=1).
// Holds a small address decoder, a bootrom (data = addr ^ 8'h21) and a WRAM.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] dec_addr;
  logic        rom_sel, wram_sel;
  logic [15:0] phys_addr;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_rdata = 8'h00;
  logic        wram_en, wram_we;
  logic [12:0] wram_addr;
  logic [7:0]  wram_wdata;
  logic [7:0]  wram_rdata = 8'h00;
  logic        boot_lock;

  int tests = 0;
  int errors = 0;

  mem_bus_ctrl #(.WAIT_STATES(1), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .dec_addr(dec_addr),
    .rom_sel(rom_sel), .wram_sel(wram_sel), .phys_addr(phys_addr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .wram_en(wram_en), .wram_we(wram_we), .wram_addr(wram_addr),
    .wram_wdata(wram_wdata), .wram_rdata(wram_rdata), .boot_lock(boot_lock)
  );

  always #5 clk = ~clk;

  // Decoder: bootrom 0000-00FF, WRAM C000-DFFF, everything else unmapped
  assign rom_sel   = (dec_addr[15:8] == 8'h00);
  assign wram_sel  = (dec_addr[15:13] == 3'b110);
  assign phys_addr = dec_addr;

  logic [7:0] wram_mem [0:8191];

  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom_addr ^ 8'h21;
    if (wram_en) begin
      if (wram_we) wram_mem[wram_addr] <= wram_wdata;
      else         wram_rdata <= wram_mem[wram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request held until ack; lat counts edges from the accepting edge
  // up to the edge at which ack is seen high.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         output int lat, output int rn, output int wn, output int wen,
                         output logic [15:0] maddr, output logic ack_low);
    lat = 0; rn = 0; wn = 0; wen = 0; maddr = 16'h0;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    do begin
      @(posedge clk); #1; lat++;
      if (rom_en) begin rn++; maddr = {8'h00, rom_addr}; end
      if (wram_en) begin
        wn++; maddr = {3'b000, wram_addr};
        if (wram_we) wen++;
      end
    end while (!cpu_ack && lat < 40);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    ack_low = !cpu_ack;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
    int          rom_n;
    int          wram_n;
    int          we_n;
    logic [15:0] maddr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, rn, wn, wen, n;
    logic [15:0] maddr;
    logic ack_low;

    vecs[0]  = '{1'b0, 16'h0010, 8'h00, 8'h31, 5, 1, 0, 0, 16'h0010};
    vecs[1]  = '{1'b1, 16'hC123, 8'hA5, 8'h31, 5, 0, 1, 1, 16'h0123};
    vecs[2]  = '{1'b0, 16'hC123, 8'h00, 8'hA5, 5, 0, 1, 0, 16'h0123};
    vecs[3]  = '{1'b0, 16'h8000, 8'h00, 8'hFF, 2, 0, 0, 0, 16'h0000};
    vecs[4]  = '{1'b1, 16'h0005, 8'h77, 8'hFF, 2, 0, 0, 0, 16'h0000};
    vecs[5]  = '{1'b0, 16'h00FF, 8'h00, 8'hDE, 5, 1, 0, 0, 16'h00FF};
    vecs[6]  = '{1'b1, 16'hDFFF, 8'h3C, 8'hDE, 5, 0, 1, 1, 16'h1FFF};
    vecs[7]  = '{1'b0, 16'hDFFF, 8'h00, 8'h3C, 5, 0, 1, 0, 16'h1FFF};
    vecs[8]  = '{1'b0, 16'hE000, 8'h00, 8'hFF, 2, 0, 0, 0, 16'h0000};
    vecs[9]  = '{1'b1, 16'hFF50, 8'h01, 8'hFF, 2, 0, 0, 0, 16'h0000};
`ifdef BOOTROM_LOCK_EN
    vecs[10] = '{1'b0, 16'h0000, 8'h00, 8'hFF, 2, 0, 0, 0, 16'h0000};
`else
    vecs[10] = '{1'b0, 16'h0000, 8'h00, 8'h21, 5, 1, 0, 0, 16'h0000};
`endif

    // Reset state
    #12;
    check("rst_ack", cpu_ack, 0);
    check("rst_rdata", cpu_rdata, 8'hFF);
    check("rst_dec_addr", dec_addr, 16'h0);
    check("rst_rom_en", rom_en, 0);
    check("rst_wram_en", wram_en, 0);
    check("rst_wram_we", wram_we, 0);
    check("rst_wdata", wram_wdata, 8'h0);
    check("rst_boot_lock", boot_lock, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rn, wn, wen, maddr, ack_low);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].rdata);
      check($sformatf("v%0d_rom_pulses", i), rn, vecs[i].rom_n);
      check($sformatf("v%0d_wram_pulses", i), wn, vecs[i].wram_n);
      check($sformatf("v%0d_wram_we_pulses", i), wen, vecs[i].we_n);
      check($sformatf("v%0d_mem_addr", i), maddr, vecs[i].maddr);
      check($sformatf("v%0d_ack_one_cycle", i), ack_low, 1);
    end
`ifdef BOOTROM_LOCK_EN
    check("boot_lock_set", boot_lock, 1);
`else
    check("boot_lock_tied", boot_lock, 0);
`endif

    // Reset during WAIT of a WRAM read
    cpu_we = 1'b0; cpu_addr = 16'hC123; cpu_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", cpu_ack, 0);
    check("midrst_rdata", cpu_rdata, 8'hFF);
    check("midrst_dec_addr", dec_addr, 16'h0);
    check("midrst_wram_en", wram_en, 0);
    check("midrst_boot_lock", boot_lock, 0);
    cpu_req = 1'b0;
    n = 0;
    repeat (3) begin @(posedge clk); #1; if (cpu_ack) n++; end
    check("midrst_no_ack", n, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 16'hC123, 8'h00, lat, rn, wn, wen, maddr, ack_low);
    check("postrst_latency", lat, 5);
    check("postrst_rdata", cpu_rdata, 8'hA5);

    // Back-to-back reads with req held high
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!cpu_ack && lat < 40);
    check("b2b_first_latency", lat, 5);
    check("b2b_first_rdata", cpu_rdata, 8'h31);
    // ack after edge A; IDLE after A+1; accepted at A+2; ack seen after A+6
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cpu_ack && n < 40);
    check("b2b_ack_spacing", n, 6);
    cpu_req = 1'b0;
    n = 0;
    repeat (8) begin @(posedge clk); #1; if (cpu_ack) n++; end
    check("b2b_no_extra_ack", n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra memory cycles between enable and data capture, legal range 0..15.
REQ-002 SHALL have parameter OPEN_BUS, default 8'hFF: read data returned for unmapped or locked addresses.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, 16) and cpu_wdata (in, 8): the CPU request.
REQ-006 SHALL have ports cpu_ack (out, 1) and cpu_rdata (out, 8): the CPU response.
REQ-007 SHALL have port dec_addr, output, 16: latched request address driven to the address decoder.
REQ-008 SHALL have ports rom_sel (in, 1), wram_sel (in, 1) and phys_addr (in, 16): combinational decoder results for dec_addr.
REQ-009 SHALL have ports rom_en (out, 1), rom_addr (out, 8) and rom_rdata (in, 8): bootrom, synchronous read.
REQ-010 SHALL have ports wram_en (out, 1), wram_we (out, 1), wram_addr (out, 13), wram_wdata (out, 8) and wram_rdata (in, 8): WRAM, synchronous.
REQ-011 SHALL have port boot_lock, output, 1: bootrom unmapped flag.

Function
REQ-012 SHALL implement FSM IDLE -> DECODE -> ACCESS -> WAIT -> RESP -> IDLE.
REQ-013 In IDLE, cpu_req=1 at an edge SHALL latch cpu_addr, cpu_we and cpu_wdata and move to DECODE.
REQ-014 In DECODE, exactly one of rom_sel/wram_sel SHALL go to ACCESS; none or both SHALL go to RESP with cpu_rdata=OPEN_BUS and no memory enable.
REQ-015 A ROM write SHALL be dropped, acked via the unmapped path, and leave cpu_rdata=OPEN_BUS.
REQ-016 ACCESS SHALL pulse the selected *_en for exactly one cycle, with rom_addr=phys_addr[7:0] or wram_addr=phys_addr[12:0], and wram_we=latched we.
REQ-017 WAIT SHALL load a 4-bit counter with WAIT_STATES and decrement it; read data SHALL be captured into cpu_rdata on the cycle the counter is 0; WAIT_STATES=0 SHALL spend one WAIT cycle.
REQ-018 RESP SHALL assert cpu_ack for exactly one cycle, hold cpu_rdata until the next ack, then return to IDLE.
REQ-019 Latency from the req-sampling edge to ack high SHALL be WAIT_STATES+4 cycles when mapped and 2 cycles when unmapped.
REQ-020 cpu_req SHALL be ignored outside IDLE; the CPU holds req until ack, and a re-asserted req is accepted at the first IDLE edge after ack.
REQ-021 Write cpu_rdata SHALL be left unchanged.

Reset
REQ-022 rst_n low SHALL force IDLE immediately, mid-transaction included, dropping the transaction without ack.
REQ-023 Reset SHALL set cpu_ack, rom_en, wram_en, wram_we and boot_lock to 0, cpu_rdata to OPEN_BUS, and dec_addr, counter and wdata latches to 0.

Configuration
REQ-024 With BOOTROM_LOCK_EN defined, a write of nonzero data to 16'hFF50 SHALL set sticky boot_lock (cleared only by reset), acked via the unmapped path.
REQ-025 With BOOTROM_LOCK_EN defined and boot_lock=1, rom_sel SHALL be treated as 0.
REQ-026 Without BOOTROM_LOCK_EN, 16'hFF50 SHALL be ordinary unmapped and boot_lock SHALL be tied 0.

Structure
REQ-027 Package sm83_bus_pkg SHALL hold the FSM state enum, OPEN_BUS default, BOOT_LOCK_ADDR=16'hFF50, ROM_AW=8 and WRAM_AW=13.
REQ-028 The design SHALL have no sub-module; the wait counter is inline and address_decode is instantiated alongside it by the parent.

Verification (WAIT_STATES=1)
REQ-029 Read 16'h0010 with rom_rdata=8'h31: ack 5 cycles after req, cpu_rdata=8'h31, rom_en one cycle, rom_addr=8'h10.
REQ-030 Write 8'hA5 to 16'hC123, then read 16'hC123 with a WRAM model: wram_addr=13'h0123, wram_we=1 only on the write, readback 8'hA5.
REQ-031 Read 16'h8000 or write to 16'h0005: ack after 2 cycles, cpu_rdata=8'hFF, no enable pulsed.
REQ-032 BOOTROM_LOCK_EN defined, write 8'h01 to 16'hFF50, then read 16'h0000: boot_lock=1, read returns 8'hFF, rom_en stays 0.
REQ-033 rst_n low during WAIT of a WRAM read: outputs immediately at reset values, no ack, next request completes normally.
REQ-034 Back-to-back reads with req held high: a second ack arrives 5 cycles after the first ack's following IDLE edge, with no missed or duplicated ack.
